// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO slice: width derivation for pointers and counters.
package fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer bundle for sync_fifo_prog: requests, thresholds and status flags.
interface sync_fifo_prog_if
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int FDEPTH = 5
);
  localparam int CWIDTH = clog2(FDEPTH + 1);

  logic [DWIDTH-1:0] data_i;
  logic              write_i;
  logic              read_i;
  logic              flush_i;
  logic [CWIDTH-1:0] af_level_i;
  logic [CWIDTH-1:0] ae_level_i;
  logic [DWIDTH-1:0] data_o;
  logic [CWIDTH-1:0] count_o;
  logic              full_o;
  logic              empty_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic              overflow_o;
  logic              underflow_o;

  modport master (
    output data_i, write_i, read_i, flush_i, af_level_i, ae_level_i,
    input  data_o, count_o, full_o, empty_o, almost_full_o, almost_empty_o,
           overflow_o, underflow_o
  );

  modport slave (
    input  data_i, write_i, read_i, flush_i, af_level_i, ae_level_i,
    output data_o, count_o, full_o, empty_o, almost_full_o, almost_empty_o,
           overflow_o, underflow_o
  );
endinterface

// File: rtl/fifo_wrap_ptr.sv
// Modulo-FDEPTH pointer: wraps FDEPTH-1 -> 0, so depth need not be a power of two.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int FDEPTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      inc,
  output logic [clog2(FDEPTH)-1:0]  ptr
);
  localparam int AWIDTH = clog2(FDEPTH);
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(FDEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ptr <= '0;
    else if (clr)        ptr <= '0;
    else if (inc) begin
      if (ptr == LAST)   ptr <= '0;
      else               ptr <= ptr + AWIDTH'(1);
    end
  end
endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous show-ahead FIFO with programmable almost flags and sticky error flags.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int FDEPTH = 5
) (
  input logic            clk,
  input logic            rst_n,
  sync_fifo_prog_if.slave bus
);
  localparam int AWIDTH = clog2(FDEPTH);
  localparam int CWIDTH = clog2(FDEPTH + 1);
  localparam logic [CWIDTH-1:0] FULL_CNT = CWIDTH'(FDEPTH);

  logic [DWIDTH-1:0] mem [FDEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [CWIDTH-1:0] count;
  logic              overflow;
  logic              underflow;
  logic              wr_en;
  logic              rd_en;
  logic              wr_go;
  logic              rd_go;

  // A write into a full FIFO is legal when the same edge pops the head.
  always_comb begin
    rd_en = bus.read_i && (count != '0);
    wr_en = bus.write_i && ((count != FULL_CNT) || bus.read_i);
    wr_go = wr_en && !bus.flush_i;
    rd_go = rd_en && !bus.flush_i;
  end

  fifo_wrap_ptr #(.FDEPTH(FDEPTH)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .clr(bus.flush_i), .inc(wr_go), .ptr(wr_ptr)
  );

  fifo_wrap_ptr #(.FDEPTH(FDEPTH)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .clr(bus.flush_i), .inc(rd_go), .ptr(rd_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.flush_i) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count <= count + CWIDTH'(1);
        2'b01:   count <= count - CWIDTH'(1);
        default: count <= count;
      endcase
      if (bus.write_i && !wr_en)      overflow  <= 1'b1;
      if (bus.read_i && (count == '0)) underflow <= 1'b1;
    end
  end

  // Storage is data-only: never reset, never cleared by flush.
  always_ff @(posedge clk) begin
    if (wr_go) mem[wr_ptr] <= bus.data_i;
  end

  assign bus.data_o         = mem[rd_ptr];
  assign bus.count_o        = count;
  assign bus.empty_o        = (count == '0);
  assign bus.full_o         = (count == FULL_CNT);
  assign bus.almost_full_o  = (count >= bus.af_level_i);
  assign bus.almost_empty_o = (count <= bus.ae_level_i);
  assign bus.overflow_o     = overflow;
  assign bus.underflow_o    = underflow;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboarded directed bench for sync_fifo_prog (DWIDTH=8, FDEPTH=5, af=4, ae=1).
module tb_sync_fifo_prog;
  localparam int DW = 8;
  localparam int FD = 5;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;
  logic [DW-1:0] exp_q [$];

  sync_fifo_prog_if #(.DWIDTH(DW), .FDEPTH(FD)) bus ();

  sync_fifo_prog #(.DWIDTH(DW), .FDEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every accepted pop presents the head word, compared to the queue front.
  always @(negedge clk) begin
    if (rst_n && bus.read_i && !bus.empty_o && !bus.flush_i) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL pop_data: got %02h, no word was expected", bus.data_o);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (bus.data_o !== e) begin
          n_miss++;
          $display("FAIL pop_data: got %02h, expected %02h", bus.data_o, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic f);
    bus.write_i = w;
    bus.read_i  = r;
    bus.data_i  = d;
    bus.flush_i = f;
    @(posedge clk);
    #1;
    bus.write_i = 1'b0;
    bus.read_i  = 1'b0;
    bus.flush_i = 1'b0;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    step(1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 1'b1, '0, 1'b0);
  endtask

  task automatic flush();
    step(1'b0, 1'b0, '0, 1'b1);
    exp_q.delete();
  endtask

  initial begin
    logic [DW-1:0] fill [5];
    fill = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    bus.data_i = '0; bus.write_i = 1'b0; bus.read_i = 1'b0; bus.flush_i = 1'b0;
    bus.af_level_i = 3'd4;
    bus.ae_level_i = 3'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(bus.count_o), 0);
    chk("rst_empty", 32'(bus.empty_o), 1);
    chk("rst_full", 32'(bus.full_o), 0);
    chk("rst_ovf", 32'(bus.overflow_o), 0);
    chk("rst_unf", 32'(bus.underflow_o), 0);
    chk("rst_aempty", 32'(bus.almost_empty_o), 1);
    chk("rst_afull", 32'(bus.almost_full_o), 0);
    rst_n = 1'b1;

    // Fill: count 1..5, almost_full at 4, full at 5, almost_empty only at 0/1.
    for (int i = 0; i < 5; i++) begin
      wr(fill[i]);
      chk("fill_count", 32'(bus.count_o), 32'(i + 1));
      chk("fill_afull", 32'(bus.almost_full_o), (i >= 3) ? 1 : 0);
      chk("fill_full", 32'(bus.full_o), (i == 4) ? 1 : 0);
      chk("fill_aempty", 32'(bus.almost_empty_o), (i == 0) ? 1 : 0);
    end
    chk("head_11", 32'(bus.data_o), 32'h11);

    // Overflow: rejected write leaves contents intact.
    wr(8'h66);
    chk("ovf_flag", 32'(bus.overflow_o), 1);
    chk("ovf_count", 32'(bus.count_o), 5);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    repeat (5) rd();
    chk("drain1_empty", 32'(bus.empty_o), 1);
    chk("ovf_sticky", 32'(bus.overflow_o), 1);
    flush();
    chk("flush_ovf", 32'(bus.overflow_o), 0);

    // Full with simultaneous read+write: pointers wrap.
    for (int i = 0; i < 5; i++) wr(fill[i]);
    exp_q.push_back(8'h11);
    step(1'b1, 1'b1, 8'h66, 1'b0);
    chk("rw_full_count", 32'(bus.count_o), 5);
    chk("rw_full_full", 32'(bus.full_o), 1);
    chk("rw_full_head", 32'(bus.data_o), 32'h22);
    chk("rw_full_ovf", 32'(bus.overflow_o), 0);
    exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    exp_q.push_back(8'h55); exp_q.push_back(8'h66);
    repeat (5) rd();
    chk("drain2_empty", 32'(bus.empty_o), 1);

    // Empty with simultaneous read+write: write wins, underflow flagged.
    step(1'b1, 1'b1, 8'hA5, 1'b0);
    chk("rw_empty_unf", 32'(bus.underflow_o), 1);
    chk("rw_empty_count", 32'(bus.count_o), 1);
    chk("rw_empty_head", 32'(bus.data_o), 32'hA5);

    // Build count 3 with both error flags, then flush while writing.
    wr(8'hB1); wr(8'hB2); wr(8'hB3); wr(8'hB4);
    wr(8'hB5);
    exp_q = '{8'hA5, 8'hB1};
    rd(); rd();
    chk("pre_flush_count", 32'(bus.count_o), 3);
    chk("pre_flush_ovf", 32'(bus.overflow_o), 1);
    chk("pre_flush_unf", 32'(bus.underflow_o), 1);
    step(1'b1, 1'b0, 8'hEE, 1'b1);
    exp_q.delete();
    chk("flush_count", 32'(bus.count_o), 0);
    chk("flush_empty", 32'(bus.empty_o), 1);
    chk("flush_ovf2", 32'(bus.overflow_o), 0);
    chk("flush_unf", 32'(bus.underflow_o), 0);

    // Live threshold change, then asynchronous reset mid-burst.
    wr(8'hC1); wr(8'hC2); wr(8'hC3);
    chk("thr_afull_before", 32'(bus.almost_full_o), 0);
    bus.af_level_i = 3'd3;
    #1;
    chk("thr_afull_after", 32'(bus.almost_full_o), 1);
    bus.ae_level_i = 3'd3;
    #1;
    chk("thr_aempty_after", 32'(bus.almost_empty_o), 1);
    bus.write_i = 1'b1;
    bus.data_i  = 8'hC4;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_empty", 32'(bus.empty_o), 1);
    chk("arst_count", 32'(bus.count_o), 0);
    bus.write_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("scoreboard_left", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 Parameter DWIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter FDEPTH, default 5, number of entries, any integer >=2 (not restricted to a power of two).
REQ-003 Derived constant AWIDTH = ceil(log2(FDEPTH)), pointer width; CWIDTH = ceil(log2(FDEPTH+1)), count width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 data_i  input  DWIDTH  write data.
REQ-007 write_i  input  1  write request.
REQ-008 read_i  input  1  read request (pop).
REQ-009 flush_i  input  1  synchronous clear.
REQ-010 af_level_i  input  CWIDTH  almost-full threshold.
REQ-011 ae_level_i  input  CWIDTH  almost-empty threshold.
REQ-012 data_o  output  DWIDTH  head-of-queue data (show-ahead).
REQ-013 count_o  output  CWIDTH  current occupancy, 0..FDEPTH.
REQ-014 full_o, empty_o, almost_full_o, almost_empty_o  output  1 each  status flags.
REQ-015 overflow_o, underflow_o  output  1 each  sticky error flags.

Function
REQ-016 A write SHALL be accepted when write_i=1 and (count<FDEPTH, or count=FDEPTH with read_i=1); the word is stored at wr_ptr on that clock edge.
REQ-017 A read SHALL be accepted when read_i=1 and count>0; rd_ptr advances on that clock edge.
REQ-018 data_o SHALL equal mem[rd_ptr] combinationally; zero-latency show-ahead; value undefined while empty_o=1.
REQ-019 Pointers SHALL wrap from FDEPTH-1 to 0; no pointer value >=FDEPTH ever reached.
REQ-020 count SHALL be +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
REQ-021 Simultaneous read+write while empty: write accepted, read rejected, underflow_o set, count becomes 1.
REQ-022 Simultaneous read+write while full: both accepted, count stays FDEPTH, full_o stays 1.
REQ-023 Rejected write (full, no read) SHALL leave memory and pointers unchanged and set overflow_o.
REQ-024 Rejected read (empty) SHALL leave pointers unchanged and set underflow_o.
REQ-025 overflow_o/underflow_o SHALL stay 1 until flush_i or reset.
REQ-026 Flags SHALL be decoded from registered count: empty_o=(count==0), full_o=(count==FDEPTH), almost_full_o=(count>=af_level_i), almost_empty_o=(count<=ae_level_i).
REQ-027 Thresholds are live inputs; a change SHALL reflect in almost flags in the same cycle.
REQ-028 flush_i SHALL take priority over write_i/read_i: pointers, count, overflow_o, underflow_o cleared next edge; requests that cycle ignored; memory contents not cleared.

Reset
REQ-029 On rst_n=0: rd_ptr=0, wr_ptr=0, count_o=0, empty_o=1, full_o=0, overflow_o=0, underflow_o=0; almost flags follow REQ-026 (almost_empty_o=1 for any ae_level_i).
REQ-030 Reset asserted mid-operation SHALL discard queued data immediately; memory array is not reset.

Structure
REQ-031 Shared package fifo_pkg SHALL hold the clog2 width function used for AWIDTH/CWIDTH.
REQ-032 One sub-module fifo_wrap_ptr (parameter FDEPTH; inputs clk, rst_n, clr, inc; output ptr) SHALL implement both pointers.
REQ-033 Storage SHALL be a register array of FDEPTH x DWIDTH, write-only clocked, no reset.

Verification (DWIDTH=8, FDEPTH=5, af=4, ae=1)
REQ-034 After reset write 0x11..0x55 -> count_o 1..5, almost_full_o at count 4, full_o at 5, data_o=0x11.
REQ-035 Full, write 0x66 without read -> overflow_o=1, count_o=5, reads return 0x11..0x55 then empty_o=1.
REQ-036 Full, read+write 0x66 -> count_o=5, data_o=0x22; drain yields 0x22,0x33,0x44,0x55,0x66 (wrap exercised).
REQ-037 Empty, read+write 0xA5 -> underflow_o=1, count_o=1, data_o=0xA5.
REQ-038 Count 3 with both overflow/underflow set, flush_i with write_i=1 -> count_o=0, empty_o=1, errors 0, no write.
REQ-039 Count 3, drop af_level_i from 4 to 3 -> almost_full_o=1 same cycle; rst_n low mid-burst -> empty_o=1 asynchronously.
